// File: rtl/rmt_pkt_phv_sync_if.sv
// AXI-Stream bundle shared by the packet input and the burst output of rmt_pkt_phv_sync.
interface rmt_pkt_phv_sync_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]  tuser;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/rmt_pkt_phv_sync.sv
// Re-joins buffered packet beats with their final-stage PHVs in order and emits AXI-Stream bursts.
// Define RMT_SYNC_STATS_EN to build the forwarded/dropped packet counters (tied to 0 otherwise).
module rmt_pkt_phv_sync #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_VEC_WIDTH        = 1024,
  parameter int PKT_DEPTH_BITS       = 8,
  parameter int PHV_DEPTH_BITS       = 4,
  parameter int DISCARD_BIT          = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  rmt_pkt_phv_sync_if.slave        s_axis,
  input  logic [PKT_VEC_WIDTH-1:0] phv_in,
  input  logic                     phv_in_valid,
  output logic                     phv_in_ready,
  rmt_pkt_phv_sync_if.master       m_axis,
  output logic [PKT_VEC_WIDTH-1:0] m_phv,
  output logic                     m_phv_first,
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              drop_cnt
);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
  localparam logic [PKT_DEPTH_BITS-1:0] PKT_PTR_ONE = {{(PKT_DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [PKT_DEPTH_BITS:0]   PKT_CNT_ONE = {{PKT_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [PHV_DEPTH_BITS-1:0] PHV_PTR_ONE = {{(PHV_DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [PHV_DEPTH_BITS:0]   PHV_CNT_ONE = {{PHV_DEPTH_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FORWARD = 2'd1, ST_DISCARD = 2'd2} state_t;

  logic [BEAT_W-1:0]        pkt_mem_r [0:(1<<PKT_DEPTH_BITS)-1];
  logic [PKT_DEPTH_BITS-1:0] pkt_wptr_r, pkt_rptr_r;
  logic [PKT_DEPTH_BITS:0]   pkt_count_r, pkt_count_nxt_s;
  logic                      pkt_full_r, pkt_empty_r, pkt_wr_s, pkt_rd_s;

  logic [PKT_VEC_WIDTH-1:0]  phv_mem_r [0:(1<<PHV_DEPTH_BITS)-1];
  logic [PHV_DEPTH_BITS-1:0] phv_wptr_r, phv_rptr_r;
  logic [PHV_DEPTH_BITS:0]   phv_count_r, phv_count_nxt_s;
  logic                      phv_full_r, phv_empty_r, phv_wr_s, phv_rd_s;

  state_t                    state_r, state_nxt_s;
  logic [BEAT_W-1:0]         pkt_head_s;
  logic [PKT_VEC_WIDTH-1:0]  phv_head_s, m_phv_r;
  logic                      head_last_s, chain_ok_s, m_valid_s, first_r;
  logic                      fwd_done_s, drop_done_s;
  state_t                    pick_s;

  assign pkt_wr_s       = s_axis.tvalid && !pkt_full_r;
  assign phv_wr_s       = phv_in_valid && !phv_full_r;
  assign s_axis.tready  = !pkt_full_r;
  assign phv_in_ready   = !phv_full_r;
  assign pkt_head_s     = pkt_mem_r[pkt_rptr_r];
  assign phv_head_s     = phv_mem_r[phv_rptr_r];
  assign head_last_s    = pkt_head_s[BEAT_W-1];
  // The next packet can start without a bubble only if a beat remains after the current pop.
  assign chain_ok_s     = !phv_empty_r && (|pkt_count_r[PKT_DEPTH_BITS:1]);
  assign pick_s         = phv_head_s[DISCARD_BIT] ? ST_DISCARD : ST_FORWARD;

  // Beat and PHV storage; contents are only meaningful between write and read pointers.
  always_ff @(posedge clk) begin
    if (pkt_wr_s) pkt_mem_r[pkt_wptr_r] <= {s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};
    if (phv_wr_s) phv_mem_r[phv_wptr_r] <= phv_in;
  end

  // Occupancy next-state for both FIFOs.
  always_comb begin
    case ({pkt_wr_s, pkt_rd_s})
      2'b10:   pkt_count_nxt_s = pkt_count_r + PKT_CNT_ONE;
      2'b01:   pkt_count_nxt_s = pkt_count_r - PKT_CNT_ONE;
      default: pkt_count_nxt_s = pkt_count_r;
    endcase
    case ({phv_wr_s, phv_rd_s})
      2'b10:   phv_count_nxt_s = phv_count_r + PHV_CNT_ONE;
      2'b01:   phv_count_nxt_s = phv_count_r - PHV_CNT_ONE;
      default: phv_count_nxt_s = phv_count_r;
    endcase
  end

  // FIFO pointers plus registered full/empty flags (full means count MSB set).
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_wptr_r  <= {PKT_DEPTH_BITS{1'b0}};
      pkt_rptr_r  <= {PKT_DEPTH_BITS{1'b0}};
      pkt_count_r <= {(PKT_DEPTH_BITS+1){1'b0}};
      pkt_full_r  <= 1'b0;
      pkt_empty_r <= 1'b1;
      phv_wptr_r  <= {PHV_DEPTH_BITS{1'b0}};
      phv_rptr_r  <= {PHV_DEPTH_BITS{1'b0}};
      phv_count_r <= {(PHV_DEPTH_BITS+1){1'b0}};
      phv_full_r  <= 1'b0;
      phv_empty_r <= 1'b1;
    end else begin
      if (pkt_wr_s) pkt_wptr_r <= pkt_wptr_r + PKT_PTR_ONE;
      if (pkt_rd_s) pkt_rptr_r <= pkt_rptr_r + PKT_PTR_ONE;
      if (phv_wr_s) phv_wptr_r <= phv_wptr_r + PHV_PTR_ONE;
      if (phv_rd_s) phv_rptr_r <= phv_rptr_r + PHV_PTR_ONE;
      pkt_count_r <= pkt_count_nxt_s;
      pkt_full_r  <= pkt_count_nxt_s[PKT_DEPTH_BITS];
      pkt_empty_r <= (pkt_count_nxt_s == {(PKT_DEPTH_BITS+1){1'b0}});
      phv_count_r <= phv_count_nxt_s;
      phv_full_r  <= phv_count_nxt_s[PHV_DEPTH_BITS];
      phv_empty_r <= (phv_count_nxt_s == {(PHV_DEPTH_BITS+1){1'b0}});
    end
  end

  // Pairing FSM: next state, FIFO pops and end-of-packet strobes.
  always_comb begin
    state_nxt_s = state_r;
    pkt_rd_s    = 1'b0;
    phv_rd_s    = 1'b0;
    fwd_done_s  = 1'b0;
    drop_done_s = 1'b0;
    m_valid_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!phv_empty_r && !pkt_empty_r) begin
          phv_rd_s    = 1'b1;
          state_nxt_s = pick_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FORWARD: begin
        m_valid_s = !pkt_empty_r;
        if (!pkt_empty_r && m_axis.tready) begin
          pkt_rd_s = 1'b1;
          if (head_last_s) begin
            fwd_done_s  = 1'b1;
            phv_rd_s    = chain_ok_s;
            state_nxt_s = chain_ok_s ? pick_s : ST_IDLE;
          end else begin
            state_nxt_s = ST_FORWARD;
          end
        end else begin
          state_nxt_s = ST_FORWARD;
        end
      end
      ST_DISCARD: begin
        if (!pkt_empty_r) begin
          pkt_rd_s = 1'b1;
          if (head_last_s) begin
            drop_done_s = 1'b1;
            phv_rd_s    = chain_ok_s;
            state_nxt_s = chain_ok_s ? pick_s : ST_IDLE;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end else begin
          state_nxt_s = ST_DISCARD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, latched PHV and first-beat marker (a fresh load wins over an accept).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      m_phv_r <= {PKT_VEC_WIDTH{1'b0}};
      first_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (phv_rd_s) m_phv_r <= phv_head_s;
      if (phv_rd_s) first_r <= 1'b1;
      else if (m_valid_s && m_axis.tready) first_r <= 1'b0;
    end
  end

  assign m_axis.tvalid = m_valid_s;
  assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} =
         m_valid_s ? pkt_head_s : {BEAT_W{1'b0}};
  assign m_phv       = m_phv_r;
  assign m_phv_first = first_r && m_valid_s;

`ifdef RMT_SYNC_STATS_EN
  logic [31:0] pkt_cnt_r, drop_cnt_r;

  // Forwarded and discarded packet counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_r  <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (fwd_done_s)  pkt_cnt_r  <= pkt_cnt_r + 32'd1;
      if (drop_done_s) drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  assign pkt_cnt  = pkt_cnt_r;
  assign drop_cnt = drop_cnt_r;
`else
  logic stats_unused_s;
  assign stats_unused_s = fwd_done_s ^ drop_done_s;
  assign pkt_cnt  = 32'd0;
  assign drop_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_rmt_pkt_phv_sync.sv
// Scoreboard bench for rmt_pkt_phv_sync: expected beats are queued as they are driven and checked at the output.
module tb_rmt_pkt_phv_sync;
  localparam int DW = 256, KW = 32, UW = 128, PW = 1024, DBIT = 128;
`ifdef RMT_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    logic [PW-1:0] p;
    logic          f;
  } beat_t;

  logic clk, reset;
  logic [PW-1:0] phv_in, m_phv;
  logic phv_in_valid, phv_in_ready, m_phv_first;
  logic [31:0] pkt_cnt, drop_cnt;
  beat_t exp_q[$];
  int total, bad;
  logic [31:0] exp_pkt, exp_drop;

  rmt_pkt_phv_sync_if s_if ();
  rmt_pkt_phv_sync_if m_if ();

  rmt_pkt_phv_sync dut (
    .clk(clk), .reset(reset), .s_axis(s_if),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .m_axis(m_if), .m_phv(m_phv), .m_phv_first(m_phv_first),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rnd_bits();
    logic [PW-1:0] r;
    for (int i = 0; i < PW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [PW-1:0] rnd_phv(input bit disc);
    logic [PW-1:0] r;
    r = rnd_bits();
    r[DBIT] = disc;
    return r;
  endfunction

  function automatic beat_t observed();
    beat_t o;
    o.d = m_if.tdata; o.k = m_if.tkeep; o.u = m_if.tuser; o.l = m_if.tlast;
    o.p = m_phv; o.f = m_phv_first;
    return o;
  endfunction

  task automatic push_phv(input logic [PW-1:0] p);
    int c;
    phv_in = p; phv_in_valid = 1'b1;
    for (c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (phv_in_ready) break;
    end
    if (c == 1000) begin total++; bad++; $display("FAIL phv_wait got=timeout exp=phv_in_ready"); end
    @(posedge clk); #1;
    phv_in_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [PW-1:0] p, input bit keep);
    beat_t b;
    logic [PW-1:0] r;
    int c;
    for (int i = 0; i < n; i++) begin
      r = rnd_bits();
      b.d = r[DW-1:0]; b.k = r[DW +: KW]; b.u = r[DW+KW +: UW];
      b.l = (i == n-1); b.p = p; b.f = (i == 0);
      if (keep) exp_q.push_back(b);
      s_if.tdata = b.d; s_if.tkeep = b.k; s_if.tuser = b.u; s_if.tlast = b.l; s_if.tvalid = 1'b1;
      for (c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (s_if.tready) break;
      end
      if (c == 1000) begin total++; bad++; $display("FAIL beat_wait got=timeout exp=s_axis_tready"); end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); exp_pkt = 32'd0; exp_drop = 32'd0;
    @(negedge clk);
    total++; if ({m_if.tvalid, m_if.tlast, m_phv_first} !== 3'b000) begin bad++; $display("FAIL rst_ctrl got=%b exp=000", {m_if.tvalid, m_if.tlast, m_phv_first}); end
    total++; if (m_if.tdata !== {DW{1'b0}} || m_if.tkeep !== {KW{1'b0}} || m_if.tuser !== {UW{1'b0}}) begin bad++; $display("FAIL rst_data got=%h exp=0", m_if.tdata); end
    total++; if (m_phv !== {PW{1'b0}}) begin bad++; $display("FAIL rst_phv got=%h exp=0", m_phv[63:0]); end
    total++; if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", pkt_cnt, drop_cnt); end
    total++; if ({s_if.tready, phv_in_ready} !== 2'b11) begin bad++; $display("FAIL rst_ready got=%b exp=11", {s_if.tready, phv_in_ready}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_empty got=%b exp=0", m_if.tvalid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    int n;
    p = rnd_phv(1'b0); m_if.tready = 1'b1; n = 0;
    fork
      push_phv(p);
      send_beats(3, p, 1'b1);
      for (int c = 0; c < 200 && n < 3; c++) begin
        @(negedge clk);
        if (m_if.tvalid) begin
          total++;
          if (observed() !== exp_q[0]) begin bad++; $display("FAIL single_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
          if (m_if.tready) begin void'(exp_q.pop_front()); n++; end
        end
      end
    join
    @(posedge clk); #1;
    exp_pkt = exp_pkt + 32'd1;
    total++; if (n != 3) begin bad++; $display("FAIL single_count got=%0d exp=3", n); end
    total++; if (pkt_cnt !== (STATS ? exp_pkt : 32'd0)) begin bad++; $display("FAIL single_pkt_cnt got=%0d exp=%0d", pkt_cnt, STATS ? exp_pkt : 32'd0); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1, p2;
    int n, cyc;
    p1 = rnd_phv(1'b0); p2 = rnd_phv(1'b0); m_if.tready = 1'b0;
    push_phv(p1); push_phv(p2);
    send_beats(2, p1, 1'b1); send_beats(4, p2, 1'b1);
    repeat (2) @(posedge clk);
    #1 m_if.tready = 1'b1; n = 0; cyc = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk); cyc++;
      if (m_if.tvalid) begin
        total++;
        if (observed() !== exp_q[0]) begin bad++; $display("FAIL b2b_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
        void'(exp_q.pop_front()); n++;
      end
    end
    @(posedge clk); #1;
    exp_pkt = exp_pkt + 32'd2;
    total++; if (cyc != 6 || n != 6) begin bad++; $display("FAIL b2b_bubble got cycles=%0d beats=%0d exp=6/6", cyc, n); end
    total++; if (pkt_cnt !== (STATS ? exp_pkt : 32'd0)) begin bad++; $display("FAIL b2b_pkt_cnt got=%0d exp=%0d", pkt_cnt, STATS ? exp_pkt : 32'd0); end
  endtask

  task automatic test_discard();
    logic [PW-1:0] pd, pn;
    int n;
    pd = rnd_phv(1'b1); pn = rnd_phv(1'b0); m_if.tready = 1'b1; n = 0;
    fork
      begin push_phv(pd); push_phv(pn); end
      begin send_beats(2, pd, 1'b0); send_beats(3, pn, 1'b1); end
      for (int c = 0; c < 200 && n < 3; c++) begin
        @(negedge clk);
        if (m_if.tvalid) begin
          total++;
          if (observed() !== exp_q[0]) begin bad++; $display("FAIL discard_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
          if (m_if.tready) begin void'(exp_q.pop_front()); n++; end
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    exp_pkt = exp_pkt + 32'd1; exp_drop = exp_drop + 32'd1;
    total++; if (n != 3 || m_if.tvalid !== 1'b0) begin bad++; $display("FAIL discard_count got=%0d valid=%b exp=3 valid=0", n, m_if.tvalid); end
    total++; if (pkt_cnt !== (STATS ? exp_pkt : 32'd0) || drop_cnt !== (STATS ? exp_drop : 32'd0)) begin bad++; $display("FAIL discard_cnt got=%0d/%0d exp=%0d/%0d", pkt_cnt, drop_cnt, STATS ? exp_pkt : 32'd0, STATS ? exp_drop : 32'd0); end
  endtask

  task automatic test_stall();
    logic [PW-1:0] p;
    int n;
    p = rnd_phv(1'b0); m_if.tready = 1'b0; n = 0;
    push_phv(p);
    send_beats(4, p, 1'b1);
    for (int c = 0; c < 40 && n < 4; c++) begin
      m_if.tready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (m_if.tvalid) begin
        total++;
        if (observed() !== exp_q[0]) begin bad++; $display("FAIL stall_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
        if (m_if.tready) begin void'(exp_q.pop_front()); n++; end
      end
      @(posedge clk); #1;
    end
    m_if.tready = 1'b1;
    exp_pkt = exp_pkt + 32'd1;
    total++; if (n != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", n); end
  endtask

  task automatic test_full();
    logic [PW-1:0] p;
    int n;
    bit chk;
    p = rnd_phv(1'b0); m_if.tready = 1'b1; n = 0; chk = 1'b0;
    send_beats(256, p, 1'b1);
    @(negedge clk);
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", s_if.tready); end
    @(posedge clk); #1;
    fork
      push_phv(p);
      for (int c = 0; c < 600 && n < 256; c++) begin
        @(negedge clk);
        if (n == 1 && !chk) begin
          chk = 1'b1;
          total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL full_release got=%b exp=1", s_if.tready); end
        end
        if (m_if.tvalid) begin
          if (n == 0) begin
            total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b exp=0", s_if.tready); end
          end
          total++;
          if (observed() !== exp_q[0]) begin bad++; $display("FAIL full_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
          void'(exp_q.pop_front()); n++;
        end
      end
    join
    @(posedge clk); #1;
    exp_pkt = exp_pkt + 32'd1;
    total++; if (n != 256) begin bad++; $display("FAIL full_count got=%0d exp=256", n); end
    total++; if (pkt_cnt !== (STATS ? exp_pkt : 32'd0)) begin bad++; $display("FAIL full_pkt_cnt got=%0d exp=%0d", pkt_cnt, STATS ? exp_pkt : 32'd0); end
  endtask

  task automatic test_reset_mid_burst();
    logic [PW-1:0] p;
    int n;
    p = rnd_phv(1'b0); m_if.tready = 1'b0; n = 0;
    push_phv(p);
    send_beats(4, p, 1'b1);
    m_if.tready = 1'b1;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      if (m_if.tvalid) begin
        total++;
        if (observed() !== exp_q[0]) begin bad++; $display("FAIL midrst_beat got d=%h exp d=%h", m_if.tdata, exp_q[0].d); end
        void'(exp_q.pop_front()); n++;
      end
    end
    @(posedge clk); #1;
    test_reset();
    p = rnd_phv(1'b0); n = 0;
    fork
      push_phv(p);
      send_beats(1, p, 1'b1);
      for (int c = 0; c < 100 && n < 1; c++) begin
        @(negedge clk);
        if (m_if.tvalid) begin
          total++;
          if (observed() !== exp_q[0]) begin bad++; $display("FAIL fresh_beat got d=%h l=%b f=%b exp d=%h l=%b f=%b", m_if.tdata, m_if.tlast, m_phv_first, exp_q[0].d, exp_q[0].l, exp_q[0].f); end
          void'(exp_q.pop_front()); n++;
        end
      end
    join
    @(posedge clk); #1;
    exp_pkt = exp_pkt + 32'd1;
    total++; if (n != 1) begin bad++; $display("FAIL fresh_count got=%0d exp=1", n); end
    total++; if (pkt_cnt !== (STATS ? exp_pkt : 32'd0)) begin bad++; $display("FAIL fresh_pkt_cnt got=%0d exp=%0d", pkt_cnt, STATS ? exp_pkt : 32'd0); end
  endtask

  initial begin
    total = 0; bad = 0; exp_pkt = 32'd0; exp_drop = 32'd0;
    reset = 1'b1;
    s_if.tdata = {DW{1'b0}}; s_if.tkeep = {KW{1'b0}}; s_if.tuser = {UW{1'b0}};
    s_if.tlast = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    phv_in = {PW{1'b0}}; phv_in_valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_discard();
    test_stall();
    test_full();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rmt_pkt_phv_sync.md
Name: rmt_pkt_phv_sync

Overview:
Parametrised packet/PHV re-join buffer that sits between the match-action stage chain and the deparser. It buffers raw packet beats from the parser-side filter and the final-stage PHVs in two internal FIFOs. It pairs them strictly in order and emits each packet as an AXI-Stream burst with its PHV on the first beat. A per-packet discard bit in the PHV drops the whole packet. Ready/valid backpressure replaces ad-hoc nearly-full wiring on both inputs.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, packet data width in bits (multiple of 64)
C_S_AXIS_TUSER_WIDTH, 128, tuser width
PKT_VEC_WIDTH, 1024, PHV width
PKT_DEPTH_BITS, 8, log2 packet-FIFO depth in beats
PHV_DEPTH_BITS, 4, log2 PHV-FIFO depth in entries
DISCARD_BIT, 128, PHV bit index that marks the packet for drop (must be < PKT_VEC_WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  packet beat
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband
s_axis_tlast  in  1  last beat
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  high when packet FIFO has at least one free entry
phv_in  in  PKT_VEC_WIDTH  PHV from last stage
phv_in_valid  in  1  PHV valid
phv_in_ready  out  1  high when PHV FIFO has at least one free entry
m_axis_tdata/tkeep/tuser/tlast  out  as s_axis  output beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_phv  out  PKT_VEC_WIDTH  PHV for the current packet, stable for the whole burst
m_phv_first  out  1  high on the first beat of each burst
pkt_cnt  out  32  packets forwarded
drop_cnt  out  32  packets discarded

Behaviour:
- Input writes: a beat is written when s_axis_tvalid&&s_axis_tready; a PHV is written when phv_in_valid&&phv_in_ready. Both FIFOs are fall-through.
- Readiness: s_axis_tready=!pkt_full and phv_in_ready=!phv_full, both registered off the FIFO counts. A write and a read in the same cycle on a full FIFO is not permitted. Ready stays low while full.
- FSM states IDLE, FORWARD, DISCARD.
  - IDLE: when PHV FIFO is non-empty and packet FIFO is non-empty, latch the PHV head into m_phv and pop the PHV. Next state is DISCARD if phv[DISCARD_BIT]=1, else FORWARD.
  - FORWARD: m_axis_tvalid = !pkt_empty; m_axis_* = packet FIFO head. A beat is popped on tvalid&&tready. m_phv_first=1 until the first beat is accepted.
  - DISCARD: pops one beat per cycle whenever packet FIFO is non-empty. No output is asserted.
  - End of packet: on pop of a tlast beat, FORWARD increments pkt_cnt and DISCARD increments drop_cnt. If another PHV and beat are available in that same cycle, latch the next PHV and go directly to FORWARD/DISCARD with no bubble; else go to IDLE.
- Latency: PHV and first beat both present in IDLE → first output beat valid on the next cycle.
- A packet whose first beat has tlast=1 is a one-beat burst; m_phv_first and tlast are both high on that beat.
- Empty packet FIFO mid-burst: tvalid drops and the FSM holds state; m_phv stays unchanged.
- m_axis_* data and m_phv are held while tvalid&&!tready (AXI stability).
- Counters are unsigned and wrap at 2^32.
- Reset state:
  - FIFOs emptied and FSM = IDLE.
  - All m_axis outputs, m_phv_first, pkt_cnt and drop_cnt are 0; m_phv is 0.
  - s_axis_tready and phv_in_ready are 1 in the first cycle after reset deassert.
  - Reset mid-packet discards all buffered content; no partial burst resumes.
- Ordering contract: the Nth PHV belongs to the Nth packet; the block does no reordering.

Optional Feature:
RMT_SYNC_STATS_EN
- Defined: pkt_cnt and drop_cnt count as above.
- Undefined: no counter registers are built; pkt_cnt and drop_cnt are tied to 0. All other behaviour is identical.

Test Plan:
1. 3-beat packet (tlast on beat 3), PHV with DISCARD_BIT=0, m_axis_tready=1 → beats out unchanged, m_phv_first only on beat 1, m_phv equals the input PHV, pkt_cnt=1.
2. Two packets back-to-back (2 beats, 4 beats), both PHVs preloaded, tready=1 → 6 consecutive valid cycles with no bubble between bursts, pkt_cnt=2.
3. PHV with DISCARD_BIT=1 followed by a normal packet → first packet absent from output, second forwarded intact, drop_cnt=1, pkt_cnt=1.
4. tready toggled 1,0,0,1 during a 4-beat burst → tdata/tkeep/tlast/m_phv stable during stalls; all 4 beats delivered in order.
5. PHV withheld until 2^PKT_DEPTH_BITS beats are buffered → s_axis_tready=0 at full. When the PHV arrives, draining proceeds and tready returns to 1 the cycle after the first pop.
6. Reset asserted mid-burst (beat 2 of 4) → next cycle after release all outputs and counters are 0 and FIFOs are empty. A fresh 1-beat packet is then forwarded with m_phv_first=1 and tlast=1.
